// File: rtl/ama_riscv_bp_gshare.sv
// ama_riscv_bp_gshare: gshare direction predictor with speculative GHR, mispredict repair and walked table init
module ama_riscv_bp_gshare #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned CNT_BITS = 2,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned CNT_INIT = 1,
  parameter int unsigned PC_LSB   = 2
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                pred_en,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispred,
  output logic [GHR_BITS-1:0] ghr,
  output logic                busy
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t state, state_nxt;
  logic [IDX_BITS-1:0] ptr;
  logic [CNT_BITS-1:0] pht [2**IDX_BITS];
  logic [CNT_BITS-1:0] upd_cur, upd_new, rd_cnt;
  logic upd_act, unused_pc;
  function automatic logic [GHR_BITS-1:0] shift(input logic [GHR_BITS-1:0] g, input logic b);
    return GHR_BITS'({g, b});
  endfunction
  assign busy = state == INIT;
  assign unused_pc = ^pred_pc;
  assign pred_idx = pred_pc[PC_LSB +: IDX_BITS] ^ IDX_BITS'(ghr);
  assign pred_ghr = ghr;
  assign upd_act = upd_en && !busy;
  assign upd_cur = pht[upd_idx];
  assign upd_new = upd_taken ? (&upd_cur ? upd_cur : upd_cur + 1'b1)
                             : (|upd_cur ? upd_cur - 1'b1 : upd_cur);
  // same-cycle update to the predicted entry is forwarded
  assign rd_cnt = (upd_act && upd_idx == pred_idx) ? upd_new : pht[pred_idx];
  assign pred_taken = !busy && rd_cnt[CNT_BITS-1];
  always_comb state_nxt = (state == INIT && ptr == '1) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= INIT;
      ptr   <= '0;
      ghr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= busy ? ptr + 1'b1 : ptr;
      if (upd_act && upd_mispred) ghr <= shift(upd_ghr, upd_taken);
      else if (pred_en && !busy)  ghr <= shift(ghr, pred_taken);
    end
  end
  always_ff @(posedge clk) begin
    if (busy)         pht[ptr]     <= CNT_BITS'(CNT_INIT);
    else if (upd_act) pht[upd_idx] <= upd_new;
  end
endmodule

// File: tb/tb_ama_riscv_bp_gshare.sv
// tb_ama_riscv_bp_gshare: directed checks of the gshare predictor with IDX=4, CNT=2, GHR=4
module tb_ama_riscv_bp_gshare;
  logic clk = 0, rst = 1, clear = 0, pred_en = 0, upd_en = 0, upd_taken = 0, upd_mispred = 0;
  logic [31:0] pred_pc = 0;
  logic [3:0] upd_idx = 0, upd_ghr = 0, pred_idx, pred_ghr, ghr;
  logic pred_taken, busy;
  int checks = 0, errors = 0;

  ama_riscv_bp_gshare #(.IDX_BITS(4), .CNT_BITS(2), .GHR_BITS(4), .CNT_INIT(1), .PC_LSB(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .pred_en(pred_en), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .ghr(ghr), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [3:0] idx, input logic tk);
    upd_en = 1; upd_idx = idx; upd_taken = tk; upd_mispred = 0;
    tick;
    upd_en = 0;
    #1;
  endtask

  task automatic restart(input logic use_rst);
    if (use_rst) rst = 1; else clear = 1;
    tick;
    rst = 0; clear = 0;
    pred_en = 1; pred_pc = 0; upd_en = 1; upd_idx = 3; upd_taken = 1; upd_mispred = 1; upd_ghr = 4'hF;
    #1;
    for (int i = 0; i < 7; i++) begin
      check("walk1_busy", busy, 1);
      check("walk1_ghr", ghr, 0);
      check("walk1_taken", pred_taken, 0);
      tick;
    end
    if (use_rst) rst = 1; else clear = 1;
    tick;
    rst = 0; clear = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("walk2_busy", busy, 1);
      check("walk2_ghr", ghr, 0);
      check("walk2_taken", pred_taken, 0);
      tick;
    end
    pred_en = 0; upd_en = 0; upd_mispred = 0;
    #1;
    check("walk_done_busy", busy, 0);
    check("walk_done_ghr", ghr, 0);
    for (int i = 0; i < 16; i++) check($sformatf("walk_cnt%0d", i), dut.pht[i], 1);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sat_pc [3];
    logic [3:0] sat_idx [3], sat_ghr [3];
    logic sat_tk [3];
    logic [1:0] up_cnt [3], dn_cnt [4];
    logic dn_tk [4];
    up_cnt = '{2'd2, 2'd3, 2'd3};
    dn_cnt = '{2'd2, 2'd1, 2'd0, 2'd0};
    dn_tk  = '{1'b1, 1'b0, 1'b0, 1'b0};
    sat_pc  = '{32'h0, 32'h0, 32'h8};
    sat_idx = '{4'd0, 4'd1, 4'd0};
    sat_ghr = '{4'd0, 4'd1, 4'd2};
    sat_tk  = '{1'b1, 1'b0, 1'b1};
    repeat (3) tick;
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      pred_pc = 32'(i * 4);
      #1;
      check("rst_busy", busy, 1);
      check("rst_ghr", ghr, 0);
      check("rst_taken", pred_taken, 0);
      tick;
    end
    check("rst_busy_done", busy, 0);
    for (int i = 0; i < 16; i++) begin
      pred_pc = 32'(i * 4);
      #1;
      check("init_idx", pred_idx, i);
      check("init_taken", pred_taken, 0);
    end
    pred_pc = 0;
    for (int k = 0; k < 3; k++) begin
      upd(0, 1);
      check("sat_up_cnt", dut.pht[0], up_cnt[k]);
      check("sat_up_taken", pred_taken, 1);
    end
    for (int k = 0; k < 4; k++) begin
      upd(0, 0);
      check("sat_dn_cnt", dut.pht[0], dn_cnt[k]);
      check("sat_dn_taken", pred_taken, dn_tk[k]);
    end
    upd_en = 1; upd_idx = 5; upd_taken = 1; pred_pc = 32'h14;
    #1;
    check("bypass_taken", pred_taken, 1);
    tick;
    upd_en = 0;
    #1;
    check("bypass_cnt", dut.pht[5], 2);
    check("bypass_read", pred_taken, 1);
    upd(0, 1);
    upd(0, 1);
    pred_en = 1;
    for (int k = 0; k < 3; k++) begin
      pred_pc = sat_pc[k];
      #1;
      check("spec_idx", pred_idx, sat_idx[k]);
      check("spec_pghr", pred_ghr, sat_ghr[k]);
      check("spec_taken", pred_taken, sat_tk[k]);
      tick;
    end
    pred_en = 0;
    #1;
    check("spec_ghr", ghr, 4'b0101);
    pred_en = 1; pred_pc = 0;
    upd_en = 1; upd_idx = 9; upd_mispred = 1; upd_ghr = 4'b0011; upd_taken = 0;
    #1;
    check("mp_pred_taken", pred_taken, 1);
    tick;
    check("mp_ghr", ghr, 4'b0110);
    upd_mispred = 0; upd_taken = 1;
    #1;
    check("nomp_pred_taken", pred_taken, 0);
    tick;
    check("nomp_ghr", ghr, 4'b1100);
    pred_en = 0; upd_en = 0;
    #1;
    restart(0);
    upd(0, 1);
    check("retrain_cnt", dut.pht[0], 2);
    restart(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
